seq_left_shifter: RTL and testbench
===================================

// Module: seq_left_shifter
// PURPOSE
//  Multi-cycle left shifter/rotator for the datapath. It complements the
//  combinational right shifter by providing logical-left and rotate-left.
//  It takes one operand per valid/ready handshake and applies one
//  power-of-two stage (1, 2, 4, 8, ...) per clock. The result is held
//  until the consumer accepts it. It sits beside the ALU for multi-cycle
//  SLL/ROL operations.
// PARAMETERS
//  N  16  data width; must equal 2**C
//  C   4  shift-count width, which is also the number of stages
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  synchronous, active-high reset
//  In         in   N  operand, sampled on accept
//  Cnt        in   C  shift amount 0..N-1, sampled on accept
//  Op         in   1  1 = logical shift left (zero fill); 0 = rotate left
//  in_valid   in   1  request valid
//  in_ready   out  1  block can accept a request this cycle
//  Out        out  N  result; meaningful only while out_valid=1
//  out_valid  out  1  result available
//  out_ready  in   1  consumer takes result this cycle
//  busy       out  1  high in SHIFT state
// BEHAVIOUR
//  Reset (rst=1 at an edge):
//   - state=IDLE, Out=0, out_valid=0, busy=0, stage index=0.
//   - An in-flight operation is discarded with no output.
//   - rst overrides every other input.
//  FSM states: IDLE, SHIFT, DONE.
//   - in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational.
//   - Accept = in_valid & in_ready at an edge. On accept:
//     latch In into the work register (drives Out), latch Cnt and Op,
//     set stage index k=0, go to SHIFT.
//   - SHIFT, each edge: if Cnt[k]=1, apply a left shift by 2**k to the
//     work register, then k=k+1.
//      - Op=1: zero-fill.
//      - Op=0: bits shifted out of the MSB re-enter at the LSB.
//     After stage k=C-1 is applied, go to DONE. in_valid is ignored.
//   - DONE: out_valid=1 and Out is stable.
//      - out_ready=1 with no accept: go to IDLE, out_valid=0.
//      - out_ready=1 and in_valid=1 at the same edge: the result is
//        consumed and the new operand is accepted (back-to-back).
//        Go to SHIFT; out_valid drops.
//      - out_ready=0: hold indefinitely.
//  Latency: out_valid rises C edges after the accept edge (4 for defaults),
//   independent of Cnt. Throughput: one operation per C+1 cycles.
//  Arithmetic:
//   - All shifts are modulo N width.
//   - Cnt=0 returns In unchanged for both Op values.
//   - Rotate by k equals rotate by k mod N. Count is never >= N by width.
//  busy=1 exactly in SHIFT. out_valid=1 exactly in DONE.
// CONFIGURATION
//  SEQ_SHIFT_EARLY_DONE_EN:
//   - Defined: in SHIFT, once all remaining bits Cnt[C-1:k+1] are 0 after
//     applying stage k, go to DONE at that edge.
//     Latency = (index of highest set Cnt bit)+1, or 1 edge when Cnt=0.
//   - Undefined: fixed latency of C edges as above.
//   - Results are identical in both builds; only timing differs.
// TESTING
//  1 In=16'h8001,Cnt=1,Op=0 -> Out=16'h0003; out_valid 4 edges after accept
//  2 In=16'h8001,Cnt=1,Op=1 -> Out=16'h0002; Cnt=0 either Op -> Out=16'h8001
//  3 In=16'h0001,Cnt=15,Op=0 -> 16'h8000; In=16'hFFFF,Cnt=8,Op=1 -> 16'hFF00
//  4 Hold out_ready=0 for 10 cycles -> Out/out_valid stable; in_ready=0;
//    then out_ready=1 with in_valid=1 -> back-to-back accept, busy next cycle
//  5 Assert rst during SHIFT (after 2nd stage) -> next cycle IDLE, Out=0,
//    out_valid=0, in_ready=1; no result is ever produced for that request
//  6 EARLY_DONE_EN: Cnt=0 -> out_valid after 1 edge; Cnt=4'b0011 -> after
//    2 edges; Cnt=4'b1000 -> after 4 edges; results match the fixed build

Source files
------------

// File: rtl/seq_left_shifter.sv
// Multi-cycle left shifter / rotator, one power-of-two stage per clock.
// Optional early completion is enabled with `define SEQ_SHIFT_EARLY_DONE_EN.
module seq_left_shifter #(
   parameter int N = 16,
   parameter int C = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] In,
   input  logic [C-1:0] Cnt,
   input  logic         Op,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] Out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   localparam logic [C-1:0] K_LAST = C'(C - 1);
   localparam logic [C-1:0] K_ONE  = C'(1);
   localparam logic [N-1:0] A_ONE  = N'(1);

   state_t         r_state;
   logic [N-1:0]   r_work;
   logic [C-1:0]   r_cnt;
   logic [C-1:0]   r_k;
   logic           r_op;
   logic           r_busy;
   logic           r_out_valid;

   logic           w_accept;
   logic           w_bit;
   logic           w_last;
   logic [N-1:0]   w_amt;
   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic [N-1:0]   w_sll;
   logic [N-1:0]   w_stage;

   assign in_ready  = (r_state == S_IDLE) |
                      ((r_state == S_DONE) & out_ready);
   assign w_accept  = in_valid & in_ready;
   assign Out       = r_work;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   // Current stage: shift by 2**k only if that count bit is set.
   assign w_bit   = |(r_cnt & (K_ONE << r_k));
   assign w_amt   = A_ONE << r_k;
   assign w_dbl   = {r_work, r_work} << w_amt;
   assign w_rot   = w_dbl[2*N-1:N];
   assign w_sll   = r_work << w_amt;
   assign w_stage = !w_bit ? r_work :
                    r_op   ? w_sll  : w_rot;

`ifdef SEQ_SHIFT_EARLY_DONE_EN
   // Finish as soon as no higher count bit remains to be applied.
   assign w_last = (((r_cnt >> r_k) >> 1) == '0);
`else
   assign w_last = (r_k == K_LAST);
`endif

   // Control FSM, work register and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_work      <= '0;
         r_cnt       <= '0;
         r_k         <= '0;
         r_op        <= 1'b0;
         r_busy      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_work  <= In;
                  r_cnt   <= Cnt;
                  r_op    <= Op;
                  r_k     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_work <= w_stage;
               r_k    <= r_k + K_ONE;
               if (w_last) begin
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (w_accept) begin
                  r_work      <= In;
                  r_cnt       <= Cnt;
                  r_op        <= Op;
                  r_k         <= '0;
                  r_busy      <= 1'b1;
                  r_out_valid <= 1'b0;
                  r_state     <= S_SHIFT;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter.
// Honours SEQ_SHIFT_EARLY_DONE_EN when computing expected latency.
module tb_seq_left_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] t_in;
   logic [3:0]  t_cnt;
   logic        t_op;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] t_out;
   logic        out_valid;
   logic        out_ready;
   logic        busy;

   int checks = 0;
   int failures = 0;
   logic [15:0] sb[$];

   seq_left_shifter #(.N(16), .C(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .In        (t_in),
      .Cnt       (t_cnt),
      .Op        (t_op),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Out       (t_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Bit-serial reference: apply a single-bit shift s times.
   function automatic logic [15:0] ref_shift(input logic [15:0] a,
                                             input logic [3:0] s,
                                             input logic op);
      logic [15:0] r;
      r = a;
      for (int i = 0; i < int'(s); i++)
         r = op ? {r[14:0], 1'b0} : {r[14:0], r[15]};
      return r;
   endfunction

   function automatic int exp_lat(input logic [3:0] c);
`ifdef SEQ_SHIFT_EARLY_DONE_EN
      int h;
      h = 0;
      for (int i = 0; i < 4; i++)
         if (c[i]) h = i;
      return h + 1;
`else
      return 4;
`endif
   endfunction

   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         tick;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s in_ready timeout got=%b want=1", tag, in_ready);
      end
   endtask

   task automatic drain(input int lat_want, input string tag);
      int lat;
      logic [15:0] exp;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick;
         lat++;
      end
      checks++;
      if (out_valid !== 1'b1 || lat != lat_want) begin
         failures++;
         $display("FAIL %s latency got=%0d want=%0d", tag, lat, lat_want);
      end
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      checks++;
      if (t_out !== exp) begin
         failures++;
         $display("FAIL %s out got=%h want=%h", tag, t_out, exp);
      end
   endtask

   task automatic do_op(input logic [15:0] a, input logic [3:0] c,
                        input logic o, input string tag);
      wait_ready(tag);
      t_in = a;
      t_cnt = c;
      t_op = o;
      in_valid = 1'b1;
      sb.push_back(ref_shift(a, c, o));
      tick;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL %s busy got=%b want=1", tag, busy);
      end
      drain(exp_lat(c), tag);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL %s release out_valid got=%b want=0", tag, out_valid);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      checks++;
      if (t_out !== 16'h0 || out_valid !== 1'b0 ||
          busy !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset out=%h ov=%b busy=%b rdy=%b want 0000/0/0/1",
                  t_out, out_valid, busy, in_ready);
      end
   endtask

   task automatic test_vectors;
      do_op(16'h8001, 4'd1,  1'b0, "rol1");
      do_op(16'h8001, 4'd1,  1'b1, "sll1");
      do_op(16'h8001, 4'd0,  1'b0, "rol0");
      do_op(16'h8001, 4'd0,  1'b1, "sll0");
      do_op(16'h0001, 4'd15, 1'b0, "rol15");
      do_op(16'hFFFF, 4'd8,  1'b1, "sll8");
      do_op(16'h8001, 4'd3,  1'b0, "rol3");
      do_op(16'hABCD, 4'd8,  1'b0, "rol8");
      do_op(16'hABCD, 4'b1000, 1'b1, "sll_c8");
      do_op(16'h1234, 4'b0011, 1'b0, "rol_c3");
   endtask

   task automatic test_back_to_back;
      logic [15:0] held;
      int bad;
      wait_ready("b2b");
      t_in = 16'h1234;
      t_cnt = 4'd5;
      t_op = 1'b0;
      in_valid = 1'b1;
      sb.push_back(ref_shift(16'h1234, 4'd5, 1'b0));
      tick;
      in_valid = 1'b0;
      drain(exp_lat(4'd5), "b2b_a");
      held = t_out;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (out_valid !== 1'b1 || t_out !== held || in_ready !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL hold unstable_cycles got=%0d want=0", bad);
      end
      t_in = 16'hF00F;
      t_cnt = 4'd4;
      t_op = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b in_ready got=%b want=1", in_ready);
      end
      sb.push_back(ref_shift(16'hF00F, 4'd4, 1'b1));
      tick;
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b state busy=%b ov=%b want 1/0", busy, out_valid);
      end
      drain(exp_lat(4'd4), "b2b_b");
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midshift;
      int seen;
      wait_ready("rst_mid");
      t_in = 16'h00FF;
      t_cnt = 4'b1111;
      t_op = 1'b0;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      checks++;
      if (t_out !== 16'h0 || out_valid !== 1'b0 ||
          in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid out=%h ov=%b rdy=%b busy=%b want 0000/0/1/0",
                  t_out, out_valid, in_ready, busy);
      end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL rst_mid ghost_out got=%0d want=0", seen);
      end
   endtask

   task automatic test_random;
      logic [15:0] a;
      logic [3:0]  c;
      logic        o;
      for (int i = 0; i < 16; i++) begin
         a = 16'($urandom);
         c = 4'($urandom_range(0, 15));
         o = 1'($urandom_range(0, 1));
         do_op(a, c, o, "rand");
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard leftover got=%0d want=0", sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      t_in = '0;
      t_cnt = '0;
      t_op = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      test_reset;
      test_vectors;
      test_back_to_back;
      test_reset_midshift;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
